// File: rtl/loader_pkg.sv
// Shared definitions for the memory boot loader: FSM state encodings and header field helpers.
package loader_pkg;

    localparam logic [2:0] ST_HDR  = 3'd0;
    localparam logic [2:0] ST_BASE = 3'd1;
    localparam logic [2:0] ST_DATA = 3'd2;
    localparam logic [2:0] ST_CSUM = 3'd3;
    localparam logic [2:0] ST_FIN  = 3'd4;
    localparam logic [2:0] ST_HALT = 3'd5;

    // A single memory still needs a one-bit select field in the header.
    function automatic int unsigned sel_width(input int unsigned n_mem);
        return (n_mem > 1) ? int'($clog2(n_mem)) : 1;
    endfunction

    // The select field sits at the top of the header word.
    function automatic int unsigned sel_lsb(input int unsigned data_w, input int unsigned n_mem);
        return data_w - sel_width(n_mem);
    endfunction

    function automatic logic sel_in_range(input logic [31:0] sel, input int unsigned n_mem);
        return sel < n_mem;
    endfunction

endpackage

// File: rtl/loader_wr_port.sv
// Registered write stage: holds address/data and drives a one-hot enable for in-range selects.
module loader_wr_port
    import loader_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned N_MEM  = 2,
    parameter int unsigned SEL_W  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              wr_i,
    input  logic [SEL_W-1:0]  sel_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [DATA_W-1:0] data_i,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [N_MEM-1:0]  mem_wren_o
);

    logic [N_MEM-1:0]  wren_d, wren_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] data_q;
    logic              sel_ok;

    assign sel_ok = sel_in_range(32'(sel_i), N_MEM);

    always_comb begin
        wren_d = '0;
        for (int unsigned m = 0; m < N_MEM; m++) begin
            wren_d[m] = wr_i && sel_ok && (32'(sel_i) == m);
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wren_q <= '0;
            addr_q <= '0;
            data_q <= '0;
        end else begin
            wren_q <= wren_d;
            if (wr_i) begin
                addr_q <= addr_i;
                data_q <= data_i;
            end
        end
    end

    assign mem_addr_o = addr_q;
    assign mem_data_o = data_q;
    assign mem_wren_o = wren_q;

endmodule

// File: rtl/mem_loader.sv
// Stream-driven boot loader: writes header/base/data segments into N_MEM memories, then starts the core.
// Define MEM_LOADER_CHECKSUM_EN to require a checksum word after each segment.
module mem_loader
    import loader_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 9,
    parameter int unsigned N_MEM  = 2
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data,
    output logic [N_MEM-1:0]  mem_wren,
    output logic              start,
    output logic              busy,
    output logic              done,
    output logic              error
);

    localparam int unsigned SEL_W   = sel_width(N_MEM);
    localparam int unsigned SEL_LSB = sel_lsb(DATA_W, N_MEM);

    if (DATA_W < SEL_W + ADDR_W) begin : g_bad_cfg
        $error("mem_loader: DATA_W must be at least SEL_W + ADDR_W");
    end

    logic [2:0]        state_q, state_d;
    logic [SEL_W-1:0]  sel_q, sel_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] sum_q, sum_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              run_q;
    logic              xfer, wr;
    logic [SEL_W-1:0]  hdr_sel;
    logic [ADDR_W-1:0] hdr_cnt;

    assign hdr_sel  = in_data[SEL_LSB +: SEL_W];
    assign hdr_cnt  = in_data[ADDR_W-1:0];
    // run_q keeps in_ready low through the reset cycles themselves.
    assign in_ready = run_q && (state_q != ST_FIN) && (state_q != ST_HALT);
    assign xfer     = in_valid && in_ready;

    always_comb begin
        state_d = state_q;
        sel_d   = sel_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        sum_d   = sum_q;
        err_d   = err_q;
        busy_d  = busy_q;
        wr      = 1'b0;
        case (state_q)
            ST_HDR: begin
                if (xfer) begin
                    if (hdr_cnt == '0) begin
                        state_d = ST_FIN;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_BASE;
                        sel_d   = hdr_sel;
                        cnt_d   = hdr_cnt;
                        sum_d   = '0;
                        busy_d  = 1'b1;
                        if (!sel_in_range(32'(hdr_sel), N_MEM)) begin
                            err_d = 1'b1;
                        end
                    end
                end
            end
            ST_BASE: begin
                if (xfer) begin
                    addr_d  = in_data[ADDR_W-1:0];
                    state_d = ST_DATA;
                end
            end
            ST_DATA: begin
                if (xfer) begin
                    wr     = 1'b1;
                    addr_d = addr_q + ADDR_W'(1);
                    cnt_d  = cnt_q - ADDR_W'(1);
                    sum_d  = sum_q + in_data;
                    if (cnt_q == ADDR_W'(1)) begin
`ifdef MEM_LOADER_CHECKSUM_EN
                        state_d = ST_CSUM;
`else
                        state_d = ST_HDR;
`endif
                    end
                end
            end
`ifdef MEM_LOADER_CHECKSUM_EN
            ST_CSUM: begin
                if (xfer) begin
                    if (in_data != sum_q) begin
                        err_d = 1'b1;
                    end
                    state_d = ST_HDR;
                end
            end
`endif
            ST_FIN:  state_d = ST_HALT;
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_HDR;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= ST_HDR;
            sel_q   <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            sum_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b0;
            run_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sel_q   <= sel_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            sum_q   <= sum_d;
            err_q   <= err_d;
            busy_q  <= busy_d;
            run_q   <= 1'b1;
        end
    end

    assign start = (state_q == ST_FIN) && !err_q;
    assign done  = (state_q == ST_FIN) || (state_q == ST_HALT);
    assign busy  = busy_q;
    assign error = err_q;

    loader_wr_port #(
        .DATA_W(DATA_W),
        .ADDR_W(ADDR_W),
        .N_MEM (N_MEM),
        .SEL_W (SEL_W)
    ) u_wr_port (
        .clock     (clock),
        .reset     (reset),
        .wr_i      (wr),
        .sel_i     (sel_q),
        .addr_i    (addr_q),
        .data_i    (in_data),
        .mem_addr_o(mem_addr),
        .mem_data_o(mem_data),
        .mem_wren_o(mem_wren)
    );

endmodule

// File: doc/mem_loader.md
# mem_loader

Hardware boot loader between an external word stream and the processor's memories. It accepts a valid/ready stream of header, base-address and data words, and writes them into one of `N_MEM` single-port memories (index 0 = instruction RAM, index 1 = data RAM). A terminator header ends the load, and the block then issues a single `start` pulse to the core. It is the synthesizable successor to loading memories from a file in simulation, generalised in word width, address width and memory count.

## Interface
Parameters:
- `DATA_W`, 16, stream and memory word width.
- `ADDR_W`, 9, memory address width; depth is 2^ADDR_W.
- `N_MEM`, 2, number of target memories.
- `SEL_W`, derived, max(1, clog2(N_MEM)).
- Constraint: `DATA_W >= SEL_W + ADDR_W`; violation is an elaboration error.

Ports:
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `in_data` in DATA_W: stream word.
- `in_valid` in 1: stream word present.
- `in_ready` out 1: loader accepts the word this cycle.
- `mem_addr` out ADDR_W: write address, shared by all memories.
- `mem_data` out DATA_W: write data, shared by all memories.
- `mem_wren` out N_MEM: one-hot write enable.
- `start` out 1: one-cycle pulse to the core.
- `busy` out 1: load in progress (past the first header, before done).
- `done` out 1: load finished; sticky until reset.
- `error` out 1: sticky error flag.

## Operation
- Handshake: a word transfers on a rising edge where `in_valid && in_ready`. `in_data` is sampled only on transfer.
- Header word fields:
  - `sel` = in_data[DATA_W-1 -: SEL_W]
  - `cnt` = in_data[ADDR_W-1:0]
  - `cnt == 0` marks the terminator.
- States:
  - HDR: on transfer, terminator goes to FIN; otherwise latch sel/cnt and go to BASE.
  - BASE: on transfer, latch address = in_data[ADDR_W-1:0] and go to DATA.
  - DATA: each transfer issues one write and increments the address modulo 2^ADDR_W (wrap, no error) and decrements the remaining count. After the last word, go to CSUM if checksum is enabled, else HDR.
  - CSUM: compare the received word with the running sum. A mismatch sets `error`. Then go to HDR.
  - FIN: if `error` is clear, pulse `start` for one cycle. Go to HALT.
  - HALT: `in_ready` = 0 and `done` = 1 until reset.
- Invalid select (`sel >= N_MEM`):
  - `error` is set when the header transfers.
  - The following base and data words are still consumed, but `mem_wren` stays all-zero.
- Multiple non-terminator headers may precede the terminator; each is a separate segment to any memory.
- The memory read path is not driven; the core owns reads after `start`.

## Timing
- Reset values: `in_ready` = 0, `mem_addr` = 0, `mem_data` = 0, `mem_wren` = 0, `start` = 0, `busy` = 0, `done` = 0, `error` = 0. State = HDR.
- `in_ready` is 1 from the first cycle after reset is released, in HDR/BASE/DATA/CSUM. It is 0 in FIN/HALT. The loader never stalls mid-load.
- Write latency is 1: a data word accepted at edge N has `mem_wren[sel]`, `mem_addr` and `mem_data` valid during cycle N+1, and the memory captures them at edge N+1. Back-to-back transfers give back-to-back writes.
- `start` is high for exactly the cycle after FIN is entered (one cycle after the terminator transfer). `done` rises in the same cycle and stays high.
- `busy` = 1 from the cycle after the first non-terminator header transfer until `done`.
- Reset asserted in any state, including mid-DATA, wins on that edge: all outputs return to reset values, no further write is issued, and partially written memory is left as is.
- `in_valid` low simply holds the state; there is no timeout.

## Configuration
- `MEM_LOADER_CHECKSUM_EN` defined:
  - Each segment is followed by one checksum word equal to the sum of its data words modulo 2^DATA_W.
  - A mismatch sets `error`, which suppresses `start`.
- Undefined: no CSUM state and no checksum word; the stream format is header, base, data words only.

## Structure
- Shared package `loader_pkg`: the state enum (HDR, BASE, DATA, CSUM, FIN, HALT) and the header field position constants/functions (SEL_W derivation, `cnt` and `sel` slices).
- Sub-module `loader_wr_port`: the registered write stage (addr/data/one-hot wren register with the sel-range check), instantiated once.
- The FSM, counters and checksum accumulator live in `mem_loader`.

## Test plan
- Defaults, checksum off: stream 0x0003, 0x0010, 0x1111, 0x2222, 0x3333, 0x0000. Expect writes to memory 0 at addresses 0x10/0x11/0x12 on consecutive cycles, `mem_wren` = 2'b01, `start` pulsed once, `done` = 1, `error` = 0.
- Data RAM select with wrap: header 0x8002, base 0x01FF, data 0xAAAA, 0xBBBB. Expect `mem_wren` = 2'b10 at address 0x1FF, then at address 0x000.
- `in_valid` toggled every other cycle during DATA: expect writes only after transfers, with the address sequence unchanged.
- With `N_MEM` = 3: header selecting memory 3 (sel = 2'b11). Expect `error` = 1, no `mem_wren`, words consumed, and no `start` after the terminator.
- Reset asserted after 2 of 4 data words: next cycle all outputs are 0 and the state is HDR; a fresh 1-word load then completes normally.
- Checksum enabled: data 0xFFFF, 0x0002 with checksum 0x0001 gives `start`. With checksum 0x0002 instead, `error` = 1 and `start` is never asserted.
